// File: rtl/sw_pkg.sv
// Shared types and default constants for the stopwatch control sequencer.
package sw_pkg;
  localparam int SW_ADDR_W     = 4;
  localparam int SW_DEB_CYCLES = 250000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STORE = 3'd4
  } sw_state_t;
endpackage

// File: rtl/sw_btn_edge.sv
// Button front end: 2-flop synchroniser, optional debounce, registered rising-edge pulse.
// Debounce stage is compiled in with SW_DEBOUNCE_EN.
module sw_btn_edge import sw_pkg::*;
`ifdef SW_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = SW_DEB_CYCLES
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;
  logic w_level;

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;

  // Debounced level flips only after DEB_CYCLES consecutive cycles at the new value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
      r_deb <= 1'b0;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end

  assign w_level = r_deb;
`else
  assign w_level = r_sync2;
`endif

  // Synchroniser and rising-edge pulse generation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/sw_ctrl_fsm.sv
// Stopwatch control sequencer: turns button presses into timer, lap-regfile and display controls.
// SW_DEBOUNCE_EN adds a DEB_CYCLES debounce stage on every button.
module sw_ctrl_fsm import sw_pkg::*; #(
  parameter int ADDR_W = SW_ADDR_W
`ifdef SW_DEBOUNCE_EN
  , parameter int DEB_CYCLES = SW_DEB_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              pause_resume,
  input  logic              record_recall,
  input  logic              recall_mode,
  input  logic [ADDR_W-1:0] reg_address,
  output logic              timer_en,
  output logic              timer_clr,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              show_live,
  output logic              started,
  output logic              paused,
  output logic              full,
  output logic              reg_exceed
);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  logic w_ss_p;
  logic w_pr_p;
  logic w_rr_p;
  logic [ADDR_W-1:0] w_lap_inc;

  sw_state_t         r_state;
  logic [ADDR_W-1:0] r_lap_ptr;
  logic [ADDR_W-1:0] r_dis_ptr;
  logic              r_timer_en;
  logic              r_timer_clr;
  logic              r_reg_we;
  logic              r_show_live;
  logic              r_started;
  logic              r_paused;

`ifdef SW_DEBOUNCE_EN
  sw_btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_ss (.clk(clk), .reset(reset), .i_btn(start_stop),    .o_pulse(w_ss_p));
  sw_btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_pr (.clk(clk), .reset(reset), .i_btn(pause_resume),  .o_pulse(w_pr_p));
  sw_btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_rr (.clk(clk), .reset(reset), .i_btn(record_recall), .o_pulse(w_rr_p));
`else
  sw_btn_edge u_ss (.clk(clk), .reset(reset), .i_btn(start_stop),    .o_pulse(w_ss_p));
  sw_btn_edge u_pr (.clk(clk), .reset(reset), .i_btn(pause_resume),  .o_pulse(w_pr_p));
  sw_btn_edge u_rr (.clk(clk), .reset(reset), .i_btn(record_recall), .o_pulse(w_rr_p));
`endif

  assign w_lap_inc = (r_lap_ptr == LAST) ? LAST : r_lap_ptr + ADDR_W'(1);

  // Sequencer: a lap write holds lap_ptr for its strobe cycle and advances it on the following edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lap_ptr   <= {ADDR_W{1'b0}};
      r_dis_ptr   <= {ADDR_W{1'b0}};
      r_timer_en  <= 1'b0;
      r_timer_clr <= 1'b0;
      r_reg_we    <= 1'b0;
      r_show_live <= 1'b0;
      r_started   <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_timer_clr <= 1'b0;
      r_reg_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_p) begin
            r_state     <= ST_CLEAR;
            r_lap_ptr   <= {ADDR_W{1'b0}};
            r_dis_ptr   <= {ADDR_W{1'b0}};
            r_timer_clr <= 1'b1;
            r_show_live <= 1'b1;
          end else if (w_rr_p) begin
            r_dis_ptr <= (r_dis_ptr == r_lap_ptr) ? {ADDR_W{1'b0}} : r_dis_ptr + ADDR_W'(1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_state    <= ST_RUN;
          r_timer_en <= 1'b1;
          r_started  <= 1'b1;
        end
        ST_RUN: begin
          if (r_reg_we) begin
            r_lap_ptr <= w_lap_inc;
            r_dis_ptr <= w_lap_inc;
          end
          if (w_ss_p) begin
            r_state    <= ST_STORE;
            r_reg_we   <= 1'b1;
            r_timer_en <= 1'b0;
            r_started  <= 1'b0;
          end else if (w_pr_p) begin
            r_state    <= ST_PAUSE;
            r_timer_en <= 1'b0;
            r_paused   <= 1'b1;
          end else if (w_rr_p) begin
            r_reg_we <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (w_ss_p) begin
            r_state   <= ST_STORE;
            r_reg_we  <= 1'b1;
            r_started <= 1'b0;
            r_paused  <= 1'b0;
          end else if (w_pr_p) begin
            r_state    <= ST_RUN;
            r_timer_en <= 1'b1;
            r_paused   <= 1'b0;
          end else begin
            r_state <= ST_PAUSE;
          end
        end
        ST_STORE: begin
          r_state     <= ST_IDLE;
          r_dis_ptr   <= r_lap_ptr;
          r_show_live <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_timer_en  <= 1'b0;
          r_show_live <= 1'b0;
          r_started   <= 1'b0;
          r_paused    <= 1'b0;
        end
      endcase
    end
  end

  assign timer_en   = r_timer_en;
  assign timer_clr  = r_timer_clr;
  assign reg_we     = r_reg_we;
  assign show_live  = r_show_live;
  assign started    = r_started;
  assign paused     = r_paused;
  assign reg_addr   = (r_state == ST_IDLE) ? (recall_mode ? reg_address : r_dis_ptr) : r_lap_ptr;
  assign full       = (r_lap_ptr == LAST);
  assign reg_exceed = recall_mode & (reg_address > r_lap_ptr);
endmodule

// File: tb/tb_sw_ctrl_fsm.sv
// Self-checking bench for sw_ctrl_fsm: directed scenarios plus random buttons against a reference model.
module tb_sw_ctrl_fsm;
`ifdef SW_DEBOUNCE_EN
  localparam int TB_DEB = 4;
`else
  localparam int TB_DEB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b0, pr = 1'b0, rr = 1'b0, rm = 1'b0;
  logic [3:0] ra = 4'd0;
  logic       timer_en, timer_clr, reg_we, show_live, started, paused, full, reg_exceed;
  logic [3:0] reg_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int wlog[$];

  sw_ctrl_fsm #(
    .ADDR_W(4)
`ifdef SW_DEBOUNCE_EN
    , .DEB_CYCLES(TB_DEB)
`endif
  ) dut (
    .clk(clk), .reset(rst),
    .start_stop(ss), .pause_resume(pr), .record_recall(rr),
    .recall_mode(rm), .reg_address(ra),
    .timer_en(timer_en), .timer_clr(timer_clr), .reg_we(reg_we), .reg_addr(reg_addr),
    .show_live(show_live), .started(started), .paused(paused),
    .full(full), .reg_exceed(reg_exceed)
  );

  always #5 clk = ~clk;

  // Log every regfile write address seen
  always @(negedge clk) begin
    if (reg_we === 1'b1) wlog.push_back(int'(reg_addr));
  end

  // Reference model: a button rise sampled at edge m is acted on at edge m+3
  typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_PAUSE, M_STORE} mphase_t;
  mphase_t    m_ph;
  int         m_lap, m_dis;
  bit         m_we;
  logic [3:0] h_ss, h_pr, h_rr;

  always @(posedge clk or posedge rst) begin : ref_model
    if (rst) begin
      m_ph <= M_IDLE; m_lap <= 0; m_dis <= 0; m_we <= 1'b0;
      h_ss <= 4'd0; h_pr <= 4'd0; h_rr <= 4'd0;
    end else begin
      automatic mphase_t ph = m_ph;
      automatic int lap = m_lap;
      automatic int dis = m_dis;
      automatic bit we = 1'b0;
      automatic bit ps = h_ss[2] & ~h_ss[3];
      automatic bit pp = h_pr[2] & ~h_pr[3];
      automatic bit pl = h_rr[2] & ~h_rr[3];
      case (ph)
        M_IDLE:  if (ps) begin ph = M_CLEAR; lap = 0; dis = 0; end
                 else if (pl) dis = (dis == lap) ? 0 : dis + 1;
        M_CLEAR: ph = M_RUN;
        M_RUN: begin
          if (m_we) begin lap = (lap < 15) ? lap + 1 : 15; dis = lap; end
          if (ps) begin ph = M_STORE; we = 1'b1; end
          else if (pp) ph = M_PAUSE;
          else if (pl) we = 1'b1;
        end
        M_PAUSE: if (ps) begin ph = M_STORE; we = 1'b1; end
                 else if (pp) ph = M_RUN;
        M_STORE: begin ph = M_IDLE; dis = lap; end
        default: ph = M_IDLE;
      endcase
      m_ph <= ph; m_lap <= lap; m_dis <= dis; m_we <= we;
      h_ss <= {h_ss[2:0], ss};
      h_pr <= {h_pr[2:0], pr};
      h_rr <= {h_rr[2:0], rr};
    end
  end

  // mask = {start_stop, pause_resume, record_recall}
  task automatic press(input logic [2:0] mask);
    @(posedge clk); #1;
    {ss, pr, rr} = mask;
    repeat (2 + TB_DEB) @(posedge clk);
    #1 {ss, pr, rr} = 3'b000;
    repeat (5 + TB_DEB) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({timer_en, timer_clr, reg_we, show_live, started, paused, full} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {timer_en, timer_clr, reg_we, show_live, started, paused, full});
    end
    n_checks++;
    if (reg_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", reg_addr); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (show_live !== 1'b0 || started !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle show_live=%b started=%b want 0 0", show_live, started);
    end
  endtask

  task automatic test_start();
    @(posedge clk); #1 ss = 1'b1;
    repeat (2 + TB_DEB) @(posedge clk);
    #1 ss = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({timer_clr, show_live, timer_en, started} !== 4'b1100) begin
      n_fail++; $display("FAIL clear_cycle clr/live/en/started got=%b want=1100",
                         {timer_clr, show_live, timer_en, started});
    end
    @(negedge clk);
    n_checks++;
    if ({timer_clr, show_live, timer_en, started, paused} !== 5'b01110) begin
      n_fail++; $display("FAIL run_entry clr/live/en/started/paused got=%b want=01110",
                         {timer_clr, show_live, timer_en, started, paused});
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_laps();
    int exp_w[4] = '{0, 1, 2, 3};
    wlog.delete();
    repeat (3) press(3'b001);
    press(3'b100);
    n_checks++;
    if (wlog.size() != 4) begin
      n_fail++; $display("FAIL lap_write_count got=%0d want=4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wlog[i] != exp_w[i]) begin
          n_fail++; $display("FAIL lap_write_addr[%0d] got=%0d want=%0d", i, wlog[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if ({show_live, started, timer_en} !== 3'b000 || reg_addr !== 4'd3) begin
      n_fail++; $display("FAIL store_to_idle live/started/en=%b addr=%0d want 000 addr 3",
                         {show_live, started, timer_en}, reg_addr);
    end
  endtask

  task automatic test_recall();
    int exp_d[5] = '{0, 1, 2, 3, 0};
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      press(3'b001);
      n_checks++;
      if (reg_addr !== exp_d[i][3:0]) begin
        n_fail++; $display("FAIL recall_step[%0d] got=%0d want=%0d", i, reg_addr, exp_d[i]);
      end
    end
    n_checks++;
    if (wlog.size() != 0) begin n_fail++; $display("FAIL idle_no_write got=%0d writes want=0", wlog.size()); end
    #1 rm = 1'b1; ra = 4'd5;
    #1;
    n_checks++;
    if (reg_exceed !== 1'b1) begin n_fail++; $display("FAIL exceed_5 got=%b want=1", reg_exceed); end
    ra = 4'd3;
    #1;
    n_checks++;
    if (reg_exceed !== 1'b0 || reg_addr !== 4'd3) begin
      n_fail++; $display("FAIL exceed_3 got exceed=%b addr=%0d want 0 3", reg_exceed, reg_addr);
    end
    rm = 1'b0; ra = 4'd0;
  endtask

  task automatic test_pause();
    press(3'b100);
    wlog.delete();
    press(3'b010);
    n_checks++;
    if ({timer_en, paused, started, show_live} !== 4'b0111) begin
      n_fail++; $display("FAIL pause_entry en/paused/started/live got=%b want=0111",
                         {timer_en, paused, started, show_live});
    end
    press(3'b001);
    n_checks++;
    if (wlog.size() != 0) begin n_fail++; $display("FAIL pause_rr_ignored got=%0d writes want=0", wlog.size()); end
    press(3'b010);
    n_checks++;
    if ({timer_en, paused} !== 2'b10) begin
      n_fail++; $display("FAIL resume en/paused got=%b want=10", {timer_en, paused});
    end
    press(3'b010);
    press(3'b100);
    n_checks++;
    if (wlog.size() != 1 || wlog[0] != 0 || show_live !== 1'b0 || paused !== 1'b0) begin
      n_fail++; $display("FAIL pause_store writes=%0d live=%b paused=%b want 1 write at 0, 0 0",
                         wlog.size(), show_live, paused);
    end
  endtask

  task automatic test_coincide();
    press(3'b100);
    wlog.delete();
    press(3'b101);
    n_checks++;
    if (wlog.size() != 1 || wlog[0] != 0 || show_live !== 1'b0) begin
      n_fail++; $display("FAIL ss_rr_coincide writes=%0d live=%b want 1 write at 0 and idle", wlog.size(), show_live);
    end
    #1 rm = 1'b1; ra = 4'd1;
    #1;
    n_checks++;
    if (reg_exceed !== 1'b1) begin n_fail++; $display("FAIL coincide_lap_held exceed got=%b want=1", reg_exceed); end
    rm = 1'b0; ra = 4'd0;
  endtask

  task automatic test_full_and_reset();
    press(3'b100);
    wlog.delete();
    for (int i = 1; i <= 17; i++) begin
      press(3'b001);
      if (i == 14) begin
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL full_after_14 got=%b want=0", full); end
      end
      if (i == 15) begin
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_15 got=%b want=1", full); end
      end
    end
    n_checks++;
    if (wlog.size() != 17) begin
      n_fail++; $display("FAIL full_write_count got=%0d want=17", wlog.size());
    end else if (wlog[14] != 14 || wlog[15] != 15 || wlog[16] != 15) begin
      n_fail++; $display("FAIL full_saturate addrs got=%0d,%0d,%0d want=14,15,15", wlog[14], wlog[15], wlog[16]);
    end
    wlog.delete();
    @(posedge clk); #1 ss = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({timer_en, started, show_live, reg_we, full} !== 5'd0) begin
      n_fail++; $display("FAIL async_reset en/started/live/we/full got=%b want=00000",
                         {timer_en, started, show_live, reg_we, full});
    end
    ss = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wlog.size() != 0 || show_live !== 1'b0 || reg_addr !== 4'd0) begin
      n_fail++; $display("FAIL reset_no_store writes=%0d live=%b addr=%0d want 0 0 0", wlog.size(), show_live, reg_addr);
    end
  endtask

`ifdef SW_DEBOUNCE_EN
  task automatic test_debounce();
    @(posedge clk); #1 ss = 1'b1;
    repeat (3) @(posedge clk);
    #1 ss = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (show_live !== 1'b0 || started !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_pulse live=%b started=%b want 0 0", show_live, started);
    end
    @(posedge clk); #1 ss = 1'b1;
    repeat (6) @(posedge clk);
    #1 ss = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (started !== 1'b1 || timer_en !== 1'b1) begin
      n_fail++; $display("FAIL press_one_pulse started=%b en=%b want 1 1", started, timer_en);
    end
  endtask
`else
  task automatic test_random();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) ss = ~ss;
      if ($urandom_range(0, 3) == 0) pr = ~pr;
      if ($urandom_range(0, 2) == 0) rr = ~rr;
      if ($urandom_range(0, 15) == 0) rm = ~rm;
      ra = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++;
      if (timer_en !== (m_ph == M_RUN) || timer_clr !== (m_ph == M_CLEAR) ||
          show_live !== (m_ph != M_IDLE) || started !== (m_ph == M_RUN || m_ph == M_PAUSE) ||
          paused !== (m_ph == M_PAUSE)) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d en/clr/live/started/paused got=%b phase=%0d",
                           c, {timer_en, timer_clr, show_live, started, paused}, m_ph);
      end
      n_checks++;
      if (reg_we !== m_we) begin
        n_fail++; $display("FAIL rand_we cyc=%0d got=%b want=%b", c, reg_we, m_we);
      end
      n_checks++;
      if (int'(reg_addr) != ((m_ph == M_IDLE) ? (rm ? int'(ra) : m_dis) : m_lap)) begin
        n_fail++; $display("FAIL rand_addr cyc=%0d got=%0d lap=%0d dis=%0d", c, reg_addr, m_lap, m_dis);
      end
      n_checks++;
      if (full !== (m_lap == 15) || reg_exceed !== (rm && int'(ra) > m_lap)) begin
        n_fail++; $display("FAIL rand_flags cyc=%0d full=%b exceed=%b lap=%0d", c, full, reg_exceed, m_lap);
      end
    end
    {ss, pr, rr, rm} = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_laps();
    test_recall();
    test_pause();
    test_coincide();
    test_full_and_reset();
`ifdef SW_DEBOUNCE_EN
    test_debounce();
`else
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
